// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the pipeline hazard controller.
//   state_e       controller state (RUN, LU_HOLD, MEM_WAIT)
//   CNT_W_DEFAULT default width of the stall/flush statistics counters
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard requests into the controller and register enables out.
//   stop, branch_taken_ex, mem_busy : hazard/memory requests (driven by master)
//   pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we :
//                                     pipeline register controls (driven by slave)
//   master : pipeline/hazard side
//   slave  : the controller
interface pipe_ctrl_if;

  logic stop;
  logic branch_taken_ex;
  logic mem_busy;
  logic pc_we;
  logic ifid_we;
  logic ifid_flush;
  logic idex_bubble;
  logic exmem_we;
  logic memwb_we;

  modport master (
    output stop, branch_taken_ex, mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we
  );

  modport slave (
    input  stop, branch_taken_ex, mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for a 5-stage pipeline.
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : pipe_ctrl_if.slave (hazard requests in, register enables out)
//   cnt_clr   : synchronous clear of the statistics counters
//   lu_cnt, mw_cnt, fl_cnt : load-use stall, memory-wait and flush cycle counts
// Build option: PIPE_CTRL_STATS_EN adds the saturating statistics counters;
// without it the counts are tied to zero and cnt_clr is ignored.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal flow; stop inserts one bubble
// LU_HOLD  | cycle after a load-use bubble; stop is stale and ignored
// MEM_WAIT | data memory busy, whole pipeline frozen
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mw_cnt,
  output logic [CNT_W-1:0] fl_cnt
);

  state_e state_q, state_d;
  logic   lu_evt, mw_evt, fl_evt;

  // Outputs react in the same cycle as the inputs; only the state is stored.
  always_comb begin
    state_d         = RUN;
    bus.pc_we       = 1'b1;
    bus.ifid_we     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.exmem_we    = 1'b1;
    bus.memwb_we    = 1'b1;
    lu_evt          = 1'b0;
    mw_evt          = 1'b0;
    fl_evt          = 1'b0;

    if (bus.mem_busy) begin
      bus.pc_we    = 1'b0;
      bus.ifid_we  = 1'b0;
      bus.exmem_we = 1'b0;
      bus.memwb_we = 1'b0;
      state_d      = MEM_WAIT;
      mw_evt       = 1'b1;
    end else if (bus.branch_taken_ex) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
      fl_evt          = 1'b1;
    end else if (bus.stop && (state_q != LU_HOLD)) begin
      // The hazard unit keeps stop high until the load leaves ID/EX, so the
      // level seen in LU_HOLD is stale; one bubble per load is enough.
      bus.pc_we       = 1'b0;
      bus.ifid_we     = 1'b0;
      bus.idex_bubble = 1'b1;
      state_d         = LU_HOLD;
      lu_evt          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst_n(rst), .inc(lu_evt), .clr(cnt_clr), .cnt(lu_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk(clk), .rst_n(rst), .inc(mw_evt), .clr(cnt_clr), .cnt(mw_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fl_cnt (
    .clk(clk), .rst_n(rst), .inc(fl_evt), .clr(cnt_clr), .cnt(fl_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats = ^{cnt_clr, lu_evt, mw_evt, fl_evt};

  assign lu_cnt = '0;
  assign mw_cnt = '0;
  assign fl_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus random checks of pipe_ctrl against a
// rule-level reference model. Runs with CNT_W=4 so saturation is reachable.
module tb_pipe_ctrl;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;
`ifdef PIPE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [W-1:0] lu_cnt, mw_cnt, fl_cnt;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr),
    .lu_cnt(lu_cnt), .mw_cnt(mw_cnt), .fl_cnt(fl_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: whether the previous cycle was a load-use bubble (a stop
  // seen in that next cycle is the same load), plus ideal event counts.
  bit prev_lu = 1'b0;
  int m_lu = 0, m_mw = 0, m_fl = 0;
  bit in_busy, in_br, in_stop, in_clr;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we}
  function automatic logic [5:0] exp_out(bit busy, bit br, bit stp, bit prev);
    bit stall;
    if (busy) return 6'b000000;
    stall = stp && !br && !prev;
    return {!stall, !stall, br, br || stall, 1'b1, 1'b1};
  endfunction

  function automatic int sat_inc(int v);
    return (v >= MAX) ? MAX : v + 1;
  endfunction

  task automatic check_out(string tag);
    logic [5:0] obs, exp;
    obs = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
           bus.exmem_we, bus.memwb_we};
    exp = exp_out(in_busy, in_br, in_stop, prev_lu);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(string tag);
    logic [3*W-1:0] obs, exp;
    obs = {lu_cnt, mw_cnt, fl_cnt};
    exp = STATS ? {m_lu[W-1:0], m_mw[W-1:0], m_fl[W-1:0]} : '0;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s counters(lu,mw,fl) observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit busy, bit br, bit stp, bit clr);
    in_busy = busy; in_br = br; in_stop = stp; in_clr = clr;
    bus.mem_busy        = busy;
    bus.branch_taken_ex = br;
    bus.stop            = stp;
    cnt_clr             = clr;
  endtask

  // One clock cycle: apply inputs, check combinational outputs, clock, check counts.
  task automatic step(string tag, bit busy, bit br, bit stp, bit clr);
    bit lu_ev, mw_ev, fl_ev;
    drive(busy, br, stp, clr);
    #1 check_out(tag);
    lu_ev = !busy && !br && stp && !prev_lu;
    mw_ev = busy;
    fl_ev = !busy && br;
    @(posedge clk);
    prev_lu = lu_ev;
    if (clr) begin
      m_lu = 0; m_mw = 0; m_fl = 0;
    end else begin
      if (lu_ev) m_lu = sat_inc(m_lu);
      if (mw_ev) m_mw = sat_inc(m_mw);
      if (fl_ev) m_fl = sat_inc(m_fl);
    end
    #1 check_cnt(tag);
  endtask

  // Hold reset for one clock edge with the given inputs applied.
  task automatic do_reset(string tag, bit busy, bit br, bit stp);
    drive(busy, br, stp, 1'b0);
    rst = 1'b0;
    prev_lu = 1'b0;
    m_lu = 0; m_mw = 0; m_fl = 0;
    #1 check_out(tag);
    check_cnt(tag);
    @(posedge clk);
    #1 check_out(tag);
    check_cnt(tag);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, and outputs follow RUN rules while in reset.
    do_reset("reset_idle", 1'b0, 1'b0, 1'b0);
    do_reset("reset_stop", 1'b0, 1'b0, 1'b1);

    step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single load-use stall.
    step("lu_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    step("lu_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stale stop held three cycles: bubbles on cycles 1 and 3 only.
    step("stale_1", 1'b0, 1'b0, 1'b1, 1'b0);
    step("stale_2", 1'b0, 1'b0, 1'b1, 1'b0);
    step("stale_3", 1'b0, 1'b0, 1'b1, 1'b0);
    step("stale_end", 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch beats load-use; afterwards a stop must stall again (back in RUN).
    step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    step("br_vs_lu", 1'b0, 1'b1, 1'b1, 1'b0);
    step("post_br_stop", 1'b0, 1'b0, 1'b1, 1'b0);
    step("post_br_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Memory wait with a pending stop, release shows the stall.
    step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("mem_wait", 1'b1, 1'b0, 1'b1, 1'b0);
    step("mem_release", 1'b0, 1'b0, 1'b1, 1'b0);
    step("mem_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while frozen in MEM_WAIT, and while in LU_HOLD.
    step("to_mem_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset("reset_mem_wait", 1'b0, 1'b0, 1'b0);
    step("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step("to_lu_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset("reset_lu_hold", 1'b0, 1'b0, 1'b1);
    step("after_reset_lu", 1'b0, 1'b0, 1'b1, 1'b0);

    // Saturation and clear-over-increment.
    step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step("fl_sat", 1'b0, 1'b1, 1'b0, 1'b0);
    step("fl_clr_br", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step("mw_sat", 1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit busy, br, stp, clr;
      busy = ($urandom_range(0, 99) < 20);
      br   = ($urandom_range(0, 99) < 25);
      stp  = ($urandom_range(0, 99) < 50);
      clr  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 79) == 0)
        do_reset("rand_reset", busy, br, stp);
      else
        step("random", busy, br, stp, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 CNT_W, default 16, width of each stall/flush statistics counter.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 stop  in  1  load-use hazard request from the hazard unit (level).
REQ-005 branch_taken_ex  in  1  taken branch/jump resolved in EX this cycle.
REQ-006 mem_busy  in  1  data memory not ready; the whole pipeline must hold.
REQ-007 cnt_clr  in  1  synchronous clear of statistics counters.
REQ-008 pc_we  out  1  PC register write enable.
REQ-009 ifid_we  out  1  IF/ID register write enable.
REQ-010 ifid_flush  out  1  load NOP into IF/ID.
REQ-011 idex_bubble  out  1  zero ID/EX control fields (insert bubble).
REQ-012 exmem_we, memwb_we  out  1 each  EX/MEM and MEM/WB write enables.
REQ-013 lu_cnt, mw_cnt, fl_cnt  out  CNT_W each  load-use stall, mem-wait and flush counts.

Function
REQ-014 The FSM SHALL have exactly three states: RUN, LU_HOLD, MEM_WAIT.
REQ-015 Outputs SHALL be combinational functions of current state and inputs (same-cycle effect); state and counters SHALL be registered.
REQ-016 Input priority SHALL be mem_busy > branch_taken_ex > stop.
REQ-017 Any state, mem_busy=1: all write enables 0, ifid_flush=0, idex_bubble=0; next state MEM_WAIT.
REQ-018 MEM_WAIT, mem_busy=0: outputs as RUN for that cycle's inputs (REQ-019..021); next state per those rules.
REQ-019 RUN or LU_HOLD, mem_busy=0, branch_taken_ex=1: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, exmem_we=memwb_we=1; stop ignored; next state RUN.
REQ-020 RUN or MEM_WAIT-exit, no branch, stop=1: pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=memwb_we=1; next state LU_HOLD.
REQ-021 No active input: all write enables 1, ifid_flush=0, idex_bubble=0; next state RUN.
REQ-022 LU_HOLD SHALL ignore stop for that one cycle (guarantees forward progress on a stale stop level); next state RUN unless REQ-017.
REQ-023 A load-use stall SHALL last exactly one cycle per load; back-to-back stop for two cycles yields one bubble.
REQ-024 Write enables to ID/EX are implicitly always 1; bubbling is done only via idex_bubble.

Reset
REQ-025 While rst=0: state RUN, counters 0; outputs follow RUN with inputs per REQ-016..021.
REQ-026 Reset asserted in LU_HOLD or MEM_WAIT SHALL abort the hold immediately; no pending stall survives reset.

Configuration
REQ-027 Macro PIPE_CTRL_STATS_EN: defined -> lu_cnt increments on every REQ-020 cycle, mw_cnt on every REQ-017 cycle, fl_cnt on every REQ-019 cycle; saturate at 2^CNT_W-1, no wrap.
REQ-028 cnt_clr=1 SHALL zero all counters that cycle, overriding any increment.
REQ-029 Macro undefined -> counters and their logic absent; lu_cnt/mw_cnt/fl_cnt tied to 0; cnt_clr ignored.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enumeration (RUN, LU_HOLD, MEM_WAIT) and default CNT_W.
REQ-031 One sub-module sat_counter (width parameter, inc, clr, async active-low reset) SHALL be instantiated three times under PIPE_CTRL_STATS_EN.

Verification
REQ-032 Load-use: stop=1 one cycle in RUN -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle; next cycle all enables 1; lu_cnt=1.
REQ-033 Stale stop: stop held 3 cycles -> bubble cycles 1 and 3 only, cycle 2 (LU_HOLD) normal; lu_cnt=2.
REQ-034 Branch vs load-use: branch_taken_ex=1, stop=1 same cycle -> ifid_flush=1, idex_bubble=1, pc_we=1; state RUN; fl_cnt=1, lu_cnt=0.
REQ-035 Memory wait: mem_busy=1 for 4 cycles with stop=1 -> all enables 0, no bubble for 4 cycles; release cycle shows load-use stall; mw_cnt=4.
REQ-036 Reset mid-wait: rst=0 in MEM_WAIT with mem_busy=0 -> state RUN, counters 0, enables 1.
REQ-037 Saturation (CNT_W=4): 20 flush cycles -> fl_cnt=15; cnt_clr with branch_taken_ex=1 -> fl_cnt=0.
